// File: rtl/axis_rand_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream random source among NUM_CONS consumers.
// Each grant lasts BURST_LEN beats; a stall watchdog reclaims the grant from a stuck consumer.
module axis_rand_arbiter #(
  parameter int unsigned NUM_CONS   = 4,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_rand_tdata,
  input  logic                  s_axis_rand_tvalid,
  output logic                  s_axis_rand_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_CONS-1:0]   m_axis_tvalid,
  input  logic [NUM_CONS-1:0]   m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  grant_valid,
  output logic [((NUM_CONS > 2) ? $clog2(NUM_CONS) : 1)-1:0] grant_idx,
  output logic                  timeout_pulse
);

  localparam int unsigned GW = (NUM_CONS > 2) ? $clog2(NUM_CONS) : 1;
  localparam int unsigned SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  localparam logic [SW-1:0] STALL_MAX = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [7:0]    BEAT_INIT = 8'(BURST_LEN - 1);
  localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_CONS - 1);
  localparam logic [GW:0]   NUM_EXT   = (GW + 1)'(NUM_CONS);

  logic          state_q, state_d;
  logic [GW-1:0] grant_idx_q, grant_idx_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          timeout_pulse_q, timeout_pulse_d;

  logic          in_burst;
  logic          granted_ready;
  logic          handshake;
  logic          stall;
  logic [GW-1:0] next_ptr;
  logic [GW-1:0] winner;
  logic          found;
  logic [GW:0]   cand;

  assign in_burst      = (state_q == ST_BURST);
  assign granted_ready = m_axis_tready[grant_idx_q];
  assign handshake     = in_burst & s_axis_rand_tvalid & granted_ready;
  assign stall         = in_burst & s_axis_rand_tvalid & ~granted_ready;
  assign next_ptr      = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + GW'(1);

  // First requester at or above rr_ptr, wrapping explicitly for non-power-of-two counts
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_CONS; i++) begin
      cand = {1'b0, rr_ptr_q} + (GW + 1)'(i);
      if (cand >= NUM_EXT) cand = cand - NUM_EXT;
      if (!found && m_axis_tready[cand[GW-1:0]]) begin
        winner = cand[GW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_idx_d     = grant_idx_q;
    rr_ptr_d        = rr_ptr_q;
    beat_cnt_d      = beat_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && found) begin
          state_d     = ST_BURST;
          grant_idx_d = winner;
          beat_cnt_d  = BEAT_INIT;
          stall_cnt_d = '0;
        end
      end
      ST_BURST: begin
        // A handshake excludes a stall in the same cycle, so the final beat always wins
        if (handshake) begin
          stall_cnt_d = '0;
          if (beat_cnt_q == 8'd0) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end else if (stall && (TIMEOUT != 0)) begin
          if (stall_cnt_q == STALL_MAX) begin
            state_d         = ST_IDLE;
            rr_ptr_d        = next_ptr;
            timeout_pulse_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q         <= ST_IDLE;
      grant_idx_q     <= '0;
      rr_ptr_q        <= '0;
      beat_cnt_q      <= '0;
      stall_cnt_q     <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_idx_q     <= grant_idx_d;
      rr_ptr_q        <= rr_ptr_d;
      beat_cnt_q      <= beat_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  always_comb begin
    m_axis_tvalid = '0;
    if (in_burst) m_axis_tvalid[grant_idx_q] = s_axis_rand_tvalid;
  end

  assign s_axis_rand_tready = in_burst & granted_ready;
  assign m_axis_tlast       = in_burst & (beat_cnt_q == 8'd0);
  assign m_axis_tdata       = s_axis_rand_tdata;
  assign grant_valid        = in_burst;
  assign grant_idx          = grant_idx_q;
  assign timeout_pulse      = timeout_pulse_q;

endmodule

// File: tb/tb_axis_rand_arbiter.sv
// Directed bench for axis_rand_arbiter: NUM_CONS=4, BURST_LEN=8, TIMEOUT=16,
// plus a TIMEOUT=0 instance sharing the same stimulus.
module tb_axis_rand_arbiter;

  logic         clk = 1'b0;
  logic         axis_areset;
  logic         enable;
  logic [255:0] s_axis_rand_tdata;
  logic         s_axis_rand_tvalid;
  logic         s_axis_rand_tready;
  logic [255:0] m_axis_tdata;
  logic [3:0]   m_axis_tvalid;
  logic [3:0]   m_axis_tready;
  logic         m_axis_tlast;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic         timeout_pulse;

  logic         nt_s_tready;
  logic [255:0] nt_m_tdata;
  logic [3:0]   nt_m_tvalid;
  logic         nt_m_tlast;
  logic         nt_grant_valid;
  logic [1:0]   nt_grant_idx;
  logic         nt_timeout_pulse;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  axis_rand_arbiter #(.NUM_CONS(4), .BURST_LEN(8), .TIMEOUT(16), .DATA_WIDTH(256)) dut (
    .axis_aclk(clk), .axis_areset(axis_areset), .enable(enable),
    .s_axis_rand_tdata(s_axis_rand_tdata), .s_axis_rand_tvalid(s_axis_rand_tvalid),
    .s_axis_rand_tready(s_axis_rand_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout_pulse(timeout_pulse)
  );

  axis_rand_arbiter #(.NUM_CONS(4), .BURST_LEN(8), .TIMEOUT(0), .DATA_WIDTH(256)) dut_nt (
    .axis_aclk(clk), .axis_areset(axis_areset), .enable(enable),
    .s_axis_rand_tdata(s_axis_rand_tdata), .s_axis_rand_tvalid(s_axis_rand_tvalid),
    .s_axis_rand_tready(nt_s_tready), .m_axis_tdata(nt_m_tdata),
    .m_axis_tvalid(nt_m_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(nt_m_tlast),
    .grant_valid(nt_grant_valid), .grant_idx(nt_grant_idx), .timeout_pulse(nt_timeout_pulse)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic new_data;
    for (int w = 0; w < 8; w++) s_axis_rand_tdata[w*32 +: 32] = $urandom();
  endtask

  task automatic do_reset;
    axis_areset = 1'b1;
    enable = 1'b0;
    s_axis_rand_tvalid = 1'b0;
    m_axis_tready = 4'b0000;
    tick;
    tick;
    axis_areset = 1'b0;
  endtask

  task automatic test_reset;
    axis_areset = 1'b1;
    enable = 1'b1;
    s_axis_rand_tvalid = 1'b1;
    m_axis_tready = 4'b1111;
    new_data;
    tick;
    tick;
    total++;
    if ({grant_valid, grant_idx, timeout_pulse, m_axis_tvalid, s_axis_rand_tready, m_axis_tlast} !== 10'b0)
      $display("FAIL reset_outputs got=%b exp=0", {grant_valid, grant_idx, timeout_pulse, m_axis_tvalid, s_axis_rand_tready, m_axis_tlast});
    else passed++;
    total++;
    if (dut.rr_ptr_q !== 2'd0) $display("FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr_q);
    else passed++;
    axis_areset = 1'b0;
  endtask

  task automatic test_single_consumer;
    do_reset;
    enable = 1'b1;
    s_axis_rand_tvalid = 1'b1;
    m_axis_tready = 4'b0100;
    #1;
    total++;
    if ({grant_valid, m_axis_tvalid, s_axis_rand_tready} !== 6'b0)
      $display("FAIL single_idle got=%b exp=0", {grant_valid, m_axis_tvalid, s_axis_rand_tready});
    else passed++;
    tick;
    for (int k = 0; k < 8; k++) begin
      new_data;
      #1;
      total++;
      if ({grant_valid, grant_idx, m_axis_tvalid, m_axis_tlast, s_axis_rand_tready} !== {1'b1, 2'd2, 4'b0100, (k == 7), 1'b1})
        $display("FAIL single_beat%0d got=%b exp=%b", k, {grant_valid, grant_idx, m_axis_tvalid, m_axis_tlast, s_axis_rand_tready},
                 {1'b1, 2'd2, 4'b0100, (k == 7), 1'b1});
      else passed++;
      total++;
      if (m_axis_tdata !== s_axis_rand_tdata) $display("FAIL single_tdata%0d got=%h exp=%h", k, m_axis_tdata, s_axis_rand_tdata);
      else passed++;
      tick;
    end
    total++;
    if ({grant_valid, m_axis_tvalid, m_axis_tlast} !== 6'b0)
      $display("FAIL single_gap got=%b exp=0", {grant_valid, m_axis_tvalid, m_axis_tlast});
    else passed++;
    tick;
    total++;
    if ({grant_valid, grant_idx} !== {1'b1, 2'd2}) $display("FAIL single_regrant got=%b exp=110", {grant_valid, grant_idx});
    else passed++;
  endtask

  task automatic test_round_robin;
    logic [1:0] e;
    logic [3:0] oh;
    do_reset;
    enable = 1'b1;
    s_axis_rand_tvalid = 1'b1;
    m_axis_tready = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      e = 2'(b % 4);
      oh = 4'b0001 << e;
      #1;
      total++;
      if (grant_valid !== 1'b0) $display("FAIL rr_idle%0d got=%b exp=0", b, grant_valid);
      else passed++;
      tick;
      for (int k = 0; k < 8; k++) begin
        total++;
        if ({grant_valid, grant_idx, m_axis_tvalid, m_axis_tlast} !== {1'b1, e, oh, (k == 7)})
          $display("FAIL rr_burst%0d_beat%0d got=%b exp=%b", b, k, {grant_valid, grant_idx, m_axis_tvalid, m_axis_tlast},
                   {1'b1, e, oh, (k == 7)});
        else passed++;
        tick;
      end
    end
  endtask

  task automatic test_watchdog;
    do_reset;
    enable = 1'b1;
    s_axis_rand_tvalid = 1'b1;
    m_axis_tready = 4'b0010;
    tick;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({grant_valid, grant_idx, s_axis_rand_tready} !== {1'b1, 2'd1, 1'b1})
        $display("FAIL wd_beat%0d got=%b exp=1011", k, {grant_valid, grant_idx, s_axis_rand_tready});
      else passed++;
      tick;
    end
    m_axis_tready = 4'b0100;
    for (int s = 1; s <= 16; s++) begin
      #1;
      total++;
      if ({grant_valid, grant_idx, m_axis_tvalid, s_axis_rand_tready, timeout_pulse} !== {1'b1, 2'd1, 4'b0010, 1'b0, 1'b0})
        $display("FAIL wd_stall%0d got=%b exp=101001000", s, {grant_valid, grant_idx, m_axis_tvalid, s_axis_rand_tready, timeout_pulse});
      else passed++;
      tick;
    end
    total++;
    if ({grant_valid, timeout_pulse} !== 2'b01) $display("FAIL wd_release got=%b exp=01", {grant_valid, timeout_pulse});
    else passed++;
    total++;
    if ({nt_grant_valid, nt_grant_idx} !== 3'b101) $display("FAIL wd_nt_held got=%b exp=101", {nt_grant_valid, nt_grant_idx});
    else passed++;
    tick;
    total++;
    if ({grant_valid, grant_idx, timeout_pulse} !== {1'b1, 2'd2, 1'b0})
      $display("FAIL wd_next_grant got=%b exp=1100", {grant_valid, grant_idx, timeout_pulse});
    else passed++;
    m_axis_tready = 4'b0000;
    repeat (40) tick;
    total++;
    if ({nt_grant_valid, nt_grant_idx, nt_m_tvalid} !== {1'b1, 2'd1, 4'b0010})
      $display("FAIL wd_nt_forever got=%b exp=1010010", {nt_grant_valid, nt_grant_idx, nt_m_tvalid});
    else passed++;
  endtask

  task automatic test_source_gaps;
    logic v;
    int done;
    do_reset;
    enable = 1'b1;
    s_axis_rand_tvalid = 1'b1;
    m_axis_tready = 4'b0001;
    tick;
    done = 0;
    for (int c = 0; c < 16; c++) begin
      v = ((c % 4) == 0) || ((c % 4) == 3);
      s_axis_rand_tvalid = v;
      #1;
      total++;
      if ({grant_valid, m_axis_tvalid, m_axis_tlast} !== {1'b1, 3'b000, v, (done == 7)})
        $display("FAIL gap_cycle%0d got=%b exp=%b", c, {grant_valid, m_axis_tvalid, m_axis_tlast}, {1'b1, 3'b000, v, (done == 7)});
      else passed++;
      if (v) done++;
      tick;
    end
    total++;
    if ({grant_valid, timeout_pulse} !== 2'b00) $display("FAIL gap_complete got=%b exp=00", {grant_valid, timeout_pulse});
    else passed++;
    s_axis_rand_tvalid = 1'b1;
    tick;
    m_axis_tready = 4'b0000;
    repeat (10) tick;
    s_axis_rand_tvalid = 1'b0;
    repeat (20) tick;
    s_axis_rand_tvalid = 1'b1;
    repeat (5) tick;
    total++;
    if ({grant_valid, timeout_pulse} !== 2'b10) $display("FAIL gap_no_count got=%b exp=10", {grant_valid, timeout_pulse});
    else passed++;
    tick;
    total++;
    if ({grant_valid, timeout_pulse} !== 2'b01) $display("FAIL gap_no_clear got=%b exp=01", {grant_valid, timeout_pulse});
    else passed++;
  endtask

  task automatic test_enable_midburst;
    do_reset;
    enable = 1'b1;
    s_axis_rand_tvalid = 1'b1;
    m_axis_tready = 4'b1000;
    tick;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) enable = 1'b0;
      #1;
      total++;
      if ({grant_valid, grant_idx, m_axis_tvalid, m_axis_tlast} !== {1'b1, 2'd3, 4'b1000, (k == 7)})
        $display("FAIL en_beat%0d got=%b exp=%b", k, {grant_valid, grant_idx, m_axis_tvalid, m_axis_tlast}, {1'b1, 2'd3, 4'b1000, (k == 7)});
      else passed++;
      tick;
    end
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({grant_valid, m_axis_tvalid} !== 5'b0) $display("FAIL en_no_grant%0d got=%b exp=0", c, {grant_valid, m_axis_tvalid});
      else passed++;
      tick;
    end
  endtask

  task automatic test_reset_midburst;
    do_reset;
    enable = 1'b1;
    s_axis_rand_tvalid = 1'b1;
    m_axis_tready = 4'b0100;
    tick;
    repeat (8) tick;
    tick;
    repeat (4) tick;
    total++;
    if ({grant_valid, grant_idx} !== 3'b110) $display("FAIL rst_pre got=%b exp=110", {grant_valid, grant_idx});
    else passed++;
    axis_areset = 1'b1;
    tick;
    total++;
    if ({grant_valid, grant_idx, timeout_pulse, m_axis_tvalid, s_axis_rand_tready, m_axis_tlast} !== 10'b0)
      $display("FAIL rst_mid_outputs got=%b exp=0", {grant_valid, grant_idx, timeout_pulse, m_axis_tvalid, s_axis_rand_tready, m_axis_tlast});
    else passed++;
    total++;
    if (dut.rr_ptr_q !== 2'd0) $display("FAIL rst_mid_rr_ptr got=%0d exp=0", dut.rr_ptr_q);
    else passed++;
    axis_areset = 1'b0;
    m_axis_tready = 4'b1100;
    tick;
    total++;
    if ({grant_valid, grant_idx} !== 3'b110) $display("FAIL rst_regrant got=%b exp=110", {grant_valid, grant_idx});
    else passed++;
  endtask

  task automatic test_last_beat_collision;
    do_reset;
    enable = 1'b1;
    s_axis_rand_tvalid = 1'b1;
    m_axis_tready = 4'b0001;
    tick;
    repeat (7) tick;
    m_axis_tready = 4'b0000;
    repeat (15) tick;
    total++;
    if ({grant_valid, m_axis_tlast, timeout_pulse} !== 3'b110) $display("FAIL col_armed got=%b exp=110", {grant_valid, m_axis_tlast, timeout_pulse});
    else passed++;
    m_axis_tready = 4'b0011;
    #1;
    total++;
    if ({s_axis_rand_tready, m_axis_tlast} !== 2'b11) $display("FAIL col_final got=%b exp=11", {s_axis_rand_tready, m_axis_tlast});
    else passed++;
    tick;
    total++;
    if ({grant_valid, timeout_pulse} !== 2'b00) $display("FAIL col_no_pulse got=%b exp=00", {grant_valid, timeout_pulse});
    else passed++;
    tick;
    total++;
    if ({grant_valid, grant_idx} !== 3'b101) $display("FAIL col_rr_advance got=%b exp=101", {grant_valid, grant_idx});
    else passed++;
  endtask

  initial begin
    axis_areset = 1'b1;
    enable = 1'b0;
    s_axis_rand_tvalid = 1'b0;
    s_axis_rand_tdata = '0;
    m_axis_tready = 4'b0000;
    test_reset;
    test_single_consumer;
    test_round_robin;
    test_watchdog;
    test_source_gaps;
    test_enable_midburst;
    test_reset_midburst;
    test_last_beat_collision;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule
